// File: rtl/pwm_pkg.sv
// Shared constants and FSM state encoding for the PWM generator/capture pair.
package pwm_pkg;

    // Frame length of the 8-bit PWM generator, in sys_clk cycles.
    localparam int PWM_PERIOD = 256;

    // Width and ceiling of the decoded duty value.
    localparam int DUTY_W   = 8;
    localparam int DUTY_MAX = 255;

    typedef enum logic [1:0] {
        ST_ACQUIRE = 2'd0,
        ST_MEASURE = 2'd1,
        ST_STATIC  = 2'd2
    } state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for the asynchronous PWM input, followed by
// registered rise/fall detection. level, rise and fall are mutually
// aligned: all three describe the same synchronized sample.
module sync_edge (
    input  logic sys_clk,
    input  logic rst,
    input  logic pwm_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic       r_meta;
    logic       r_sync;
    logic       r_sync_d;
    logic [2:0] r_primed;

    // Synchronize, delay by one cycle and register the edge strobes.
    // Edges are reported only once the delayed copy holds a real sample,
    // so an input that is already high when reset releases is not taken
    // for a rising edge.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_sync_d <= 1'b0;
            r_primed <= 3'b000;
            level    <= 1'b0;
            rise     <= 1'b0;
            fall     <= 1'b0;
        end else begin
            r_meta   <= pwm_in;
            r_sync   <= r_meta;
            r_sync_d <= r_sync;
            r_primed <= {r_primed[1:0], 1'b1};
            level    <= r_sync;
            rise     <= r_primed[2] &  r_sync & ~r_sync_d;
            fall     <= r_primed[2] & ~r_sync &  r_sync_d;
        end
    end

endmodule

// File: rtl/pwm_capture.sv
// PWM decoder: measures frame length and high time between rising edges,
// and reports a static level when no rising edge arrives within TIMEOUT.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int PERIOD  = PWM_PERIOD,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              pwm_in,
    output logic [DUTY_W-1:0] duty,
    output logic [CNT_W-1:0]  period,
    output logic              valid,
    output logic              locked
);

    logic             w_level;
    logic             w_rise;
    logic             w_fall;

    state_t           r_state;
    state_t           w_next;

    logic [CNT_W-1:0] r_period_cnt;
    logic [CNT_W-1:0] r_high_cnt;
    logic [CNT_W-1:0] r_idle_cnt;

    logic             w_start;
    logic             w_measure;
    logic             w_timeout;
    logic             w_static_fall;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

    function automatic logic [DUTY_W-1:0] sat_duty(input logic [CNT_W-1:0] c);
        return (c > CNT_W'(DUTY_MAX)) ? DUTY_W'(DUTY_MAX) : c[DUTY_W-1:0];
    endfunction

    sync_edge u_sync_edge (
        .sys_clk (sys_clk),
        .rst     (rst),
        .pwm_in  (pwm_in),
        .level   (w_level),
        .rise    (w_rise),
        .fall    (w_fall)
    );

    // FSM state register.
    always_ff @(posedge sys_clk) begin
        if (rst) r_state <= ST_ACQUIRE;
        else     r_state <= w_next;
    end

    // Next state and event strobes; a rise always wins over a timeout.
    always_comb begin
        w_next        = r_state;
        w_start       = 1'b0;
        w_measure     = 1'b0;
        w_timeout     = 1'b0;
        w_static_fall = 1'b0;
        case (r_state)
            ST_ACQUIRE: begin
                if (w_rise) begin
                    w_next  = ST_MEASURE;
                    w_start = 1'b1;
                end else if (r_idle_cnt >= CNT_W'(TIMEOUT)) begin
                    w_next    = ST_STATIC;
                    w_timeout = 1'b1;
                end
            end
            ST_MEASURE: begin
                if (w_rise) begin
                    w_measure = 1'b1;
                    w_start   = 1'b1;
                end else if (r_period_cnt >= CNT_W'(TIMEOUT)) begin
                    w_next    = ST_STATIC;
                    w_timeout = 1'b1;
                end
            end
            ST_STATIC: begin
                if (w_rise) begin
                    w_next  = ST_MEASURE;
                    w_start = 1'b1;
                end else if (w_fall) begin
                    w_static_fall = 1'b1;
                end
            end
            default: w_next = ST_ACQUIRE;
        endcase
    end

    // Frame and high-time counters; the rising-edge cycle counts as 1.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_period_cnt <= '0;
            r_high_cnt   <= '0;
            r_idle_cnt   <= '0;
        end else begin
            if (w_start) begin
                r_period_cnt <= CNT_W'(1);
                r_high_cnt   <= CNT_W'(1);
            end else if (r_state == ST_MEASURE) begin
                r_period_cnt <= sat_inc(r_period_cnt);
                if (w_level) r_high_cnt <= sat_inc(r_high_cnt);
            end
            if (r_state == ST_ACQUIRE) r_idle_cnt <= sat_inc(r_idle_cnt);
        end
    end

    // Registered results and the one-cycle valid strobe.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            duty   <= '0;
            period <= '0;
            valid  <= 1'b0;
            locked <= 1'b0;
        end else begin
            valid <= w_measure | w_timeout | w_static_fall;
            if (w_measure) begin
                period <= r_period_cnt;
                duty   <= sat_duty(r_high_cnt);
                locked <= (r_period_cnt == CNT_W'(PERIOD));
            end else if (w_timeout) begin
                period <= '0;
                duty   <= w_level ? DUTY_W'(DUTY_MAX) : '0;
                locked <= 1'b0;
            end else if (w_static_fall) begin
                duty   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture, with a behavioural 8-bit-style PWM generator.
module tb_pwm_capture;
    import pwm_pkg::*;

    logic        sys_clk = 1'b0;
    logic        rst     = 1'b1;
    logic        pwm_in  = 1'b0;
    logic [7:0]  duty;
    logic [15:0] period;
    logic        valid;
    logic        locked;

    int n_chk  = 0;
    int n_pass = 0;

    // Generator state: high while gen_cnt < gen_high, gen_din loaded at frame start.
    bit gen_en     = 1'b0;
    bit gen_level  = 1'b0;
    int gen_period = PWM_PERIOD;
    int gen_din    = 0;
    int gen_high   = 0;
    int gen_cnt    = 0;

    int cyc          = 0;
    int last_chg_cyc = 0;
    int rise_cnt     = 0;

    pwm_capture #(
        .PERIOD  (PWM_PERIOD),
        .TIMEOUT (1024),
        .CNT_W   (16)
    ) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .pwm_in  (pwm_in),
        .duty    (duty),
        .period  (period),
        .valid   (valid),
        .locked  (locked)
    );

    initial forever #5 sys_clk = ~sys_clk;

    // pwm_in changes 1 time unit after edge cyc and is first sampled at edge cyc+1.
    initial begin
        bit pwm_new;
        forever begin
            @(posedge sys_clk);
            cyc++;
            #1;
            if (gen_en) begin
                if (gen_cnt == 0) gen_high = gen_din;
                pwm_new = (gen_cnt < gen_high);
                gen_cnt = (gen_cnt + 1 == gen_period) ? 0 : gen_cnt + 1;
            end else begin
                pwm_new = gen_level;
            end
            if (pwm_new != pwm_in) last_chg_cyc = cyc;
            if (pwm_new && !pwm_in) rise_cnt++;
            pwm_in = pwm_new;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic do_reset();
        gen_en = 1'b0;
        @(negedge sys_clk);
        rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        rst = 1'b0;
    endtask

    task automatic start_gen(input int per, input int high);
        gen_period = per;
        gen_din    = high;
        gen_cnt    = 0;
        gen_en     = 1'b1;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge sys_clk);
            if (valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    task automatic wait_cnt(input string tag, input int target, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge sys_clk);
            if (gen_cnt == target) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    task automatic count_valid(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge sys_clk);
            if (valid === 1'b1) cnt++;
        end
    endtask

    initial begin
        int r0;
        int t0;
        int n;

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        chk("reset duty", duty, 0);
        chk("reset period", period, 0);
        chk("reset valid", valid, 0);
        chk("reset locked", locked, 0);
        rst = 1'b0;

        // 256-cycle frames, 64 high: first result after the second rise
        start_gen(256, 64);
        r0 = rise_cnt;
        wait_valid("p256 first valid", 700);
        chk("p256 latency", cyc - last_chg_cyc, 4);
        chk("p256 rises before valid", rise_cnt - r0, 2);
        chk("p256 duty", duty, 64);
        chk("p256 period", period, 256);
        chk("p256 locked", locked, 1);
        t0 = cyc;
        wait_valid("p256 second valid", 300);
        chk("p256 repeat gap", cyc - t0, 256);
        chk("p256 duty again", duty, 64);
        chk("p256 locked again", locked, 1);

        // Input stops low while measuring: timeout to static low
        gen_level = 1'b0;
        gen_en    = 1'b0;
        wait_valid("measure timeout valid", 1300);
        chk("measure timeout duty", duty, 0);
        chk("measure timeout period", period, 0);
        chk("measure timeout locked", locked, 0);
        count_valid(1100, n);
        chk("static low no more pulses", n, 0);

        // Held low from reset
        gen_level = 1'b0;
        do_reset();
        wait_valid("idle low valid", 1100);
        chk("idle low duty", duty, 0);
        chk("idle low period", period, 0);
        chk("idle low locked", locked, 0);
        count_valid(1100, n);
        chk("idle low single pulse", n, 0);

        // Held high from reset, then dropped, then raised again
        gen_level = 1'b1;
        do_reset();
        wait_valid("idle high valid", 1100);
        chk("idle high duty", duty, 255);
        chk("idle high period", period, 0);
        chk("idle high locked", locked, 0);
        count_valid(200, n);
        chk("idle high single pulse", n, 0);
        gen_level = 1'b0;
        wait_valid("static fall valid", 10);
        chk("static fall latency", cyc - last_chg_cyc, 4);
        chk("static fall duty", duty, 0);
        chk("static fall period", period, 0);
        gen_level = 1'b1;
        count_valid(20, n);
        chk("static rise no pulse", n, 0);

        // 200-cycle frames, 100 high
        gen_level = 1'b0;
        do_reset();
        start_gen(200, 100);
        wait_valid("p200 valid", 700);
        chk("p200 duty", duty, 100);
        chk("p200 period", period, 200);
        chk("p200 locked", locked, 0);

        // 400-cycle frames, 300 high: duty saturates
        do_reset();
        start_gen(400, 300);
        wait_valid("p400 valid", 1000);
        chk("p400 duty", duty, 255);
        chk("p400 period", period, 400);
        chk("p400 locked", locked, 0);

        // Reset 100 cycles into a 256/128 frame
        do_reset();
        start_gen(256, 128);
        wait_valid("p256h128 valid", 700);
        chk("p256h128 duty", duty, 128);
        chk("p256h128 locked", locked, 1);
        wait_cnt("reach frame offset 100", 100, 300);
        rst = 1'b1;
        @(negedge sys_clk);
        rst = 1'b0;
        chk("midreset duty", duty, 0);
        chk("midreset period", period, 0);
        chk("midreset valid", valid, 0);
        chk("midreset locked", locked, 0);
        r0 = rise_cnt;
        wait_valid("post reset valid", 800);
        chk("post reset rises", rise_cnt - r0, 2);
        chk("post reset duty", duty, 128);
        chk("post reset period", period, 256);
        chk("post reset locked", locked, 1);

        // Generator sweep: each valid reports the frame loaded one step earlier
        do_reset();
        start_gen(256, 1);
        for (int d = 2; d <= 256; d++) begin
            wait_cnt("sweep frame end", 246, 300);
            gen_din = (d <= 255) ? d : 255;
            wait_valid("sweep valid", 300);
            chk($sformatf("sweep duty din=%0d", d - 1), duty, d - 1);
        end
        wait_cnt("sweep frame end", 246, 300);
        gen_din = 0;
        wait_valid("sweep din0 valid", 1300);
        chk("sweep din0 duty", duty, 0);
        chk("sweep din0 period", period, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
